// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch-stage PC sequencer.
// Used by pc_sequencer and pc_next_mux.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_BR   = 2'd1,
    SRC_JMP  = 2'd2,
    SRC_EXC  = 2'd3
  } redir_src_t;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h8000_0180;

  function automatic logic [31:0] word_align(
    input logic [31:0] a
  );
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Priority redirect-target select (exc > jmp > br) plus
// the sequential PC+4 path.
module pc_next_mux
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
  input  logic [31:0] pc,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp,
  input  logic [31:0] jmp_target,
  input  logic        exc,
  output redir_src_t  src,
  output logic [31:0] target,
  output logic [31:0] seq_pc
);

  always_comb begin
    src    = SRC_NONE;
    target = '0;
    priority case (1'b1)
      exc: begin
        src    = SRC_EXC;
        target = word_align(EXC_VECTOR);
      end
      jmp: begin
        src    = SRC_JMP;
        target = word_align(jmp_target);
      end
      br_taken: begin
        src    = SRC_BR;
        target = word_align(br_target);
      end
      default: ;
    endcase
  end

  assign seq_pc = pc + 32'd4;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: owns the PC, drives imem req/ack.
// Optional counters under `define PC_SEQ_PERF_EN.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [31:0] EXC_VECTOR   = DEF_EXC_VECTOR
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp,
  input  logic [31:0] jmp_target,
  input  logic        exc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
`ifdef PC_SEQ_PERF_EN
  output logic [31:0] perf_fetch,
  output logic [31:0] perf_squash,
  output logic [31:0] perf_stall,
`endif
  output logic [31:0] pc_out
);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        v_q, v_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic [31:0] redir_q, redir_d;
  logic        rexc_q, rexc_d;
  logic        hold_q, hold_d;

  redir_src_t  src;
  logic [31:0] target;
  logic [31:0] seq_pc;
  logic        redir;
  logic        hold_if;
  logic        take_new;
  logic [31:0] drain_tgt;
  logic        drain_exc;
  logic        pend;

  pc_next_mux #(
    .EXC_VECTOR (EXC_VECTOR)
  ) u_mux (
    .pc         (pc_q),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .jmp        (jmp),
    .jmp_target (jmp_target),
    .exc        (exc),
    .src        (src),
    .target     (target),
    .seq_pc     (seq_pc)
  );

  assign redir   = src != SRC_NONE;
  assign hold_if = stall && v_q;
  assign pend    = imem_req && !imem_ack;

  // a pending exception target survives later br/jmp
  assign take_new  = redir && !(rexc_q && src != SRC_EXC);
  assign drain_tgt = take_new ? target : redir_q;
  assign drain_exc = take_new ? (src == SRC_EXC) : rexc_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= BOOT;
      pc_q    <= word_align(RESET_VECTOR);
      v_q     <= 1'b0;
      instr_q <= '0;
      ipc_q   <= '0;
      redir_q <= '0;
      rexc_q  <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      v_q     <= v_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      redir_q <= redir_d;
      rexc_q  <= rexc_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    v_d     = v_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    redir_d = redir_q;
    rexc_d  = rexc_q;
    hold_d  = hold_q;
    unique case (state_q)
      BOOT: begin
        state_d = REQ;
        if (redir) pc_d = target;
      end
      REQ: begin
        hold_d = pend;
        if (redir) begin
          v_d = 1'b0;
          if (pend) begin
            state_d = DRAIN;
            redir_d = target;
            rexc_d  = src == SRC_EXC;
          end else begin
            pc_d = target;
          end
        end else if (imem_req && imem_ack) begin
          // an in-flight fetch landing behind a stall is replayed
          if (!hold_if) begin
            instr_d = imem_rdata;
            ipc_d   = pc_q;
            v_d     = 1'b1;
            pc_d    = seq_pc;
          end
        end else if (!stall) begin
          v_d = 1'b0;
        end
      end
      DRAIN: begin
        v_d     = 1'b0;
        redir_d = drain_tgt;
        rexc_d  = drain_exc;
        if (imem_ack) begin
          pc_d    = drain_tgt;
          rexc_d  = 1'b0;
          hold_d  = 1'b0;
          state_d = REQ;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    imem_req = 1'b0;
    unique case (state_q)
      BOOT:    imem_req = 1'b0;
      REQ:     imem_req = hold_q || !hold_if;
      DRAIN:   imem_req = 1'b1;
      default: imem_req = 1'b0;
    endcase
  end

  assign imem_addr = pc_q;
  assign pc_out    = pc_q;
  assign if_valid  = v_q;
  assign if_instr  = instr_q;
  assign if_pc     = ipc_q;

`ifdef PC_SEQ_PERF_EN
  logic ack_ok;
  logic acc;
  logic sq;

  assign ack_ok = imem_req && imem_ack;
  assign acc = ack_ok && state_q == REQ
            && !redir && !hold_if;
  assign sq  = ack_ok && !acc;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_fetch  <= '0;
      perf_squash <= '0;
      perf_stall  <= '0;
    end else begin
      if (acc)     perf_fetch  <= perf_fetch + 32'd1;
      if (sq)      perf_squash <= perf_squash + 32'd1;
      if (hold_if) perf_stall  <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer.
// Memory model returns addr ^ 32'hCAFE_0000.
module tb_pc_sequencer;

  logic        clk;
  logic        rstn;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jmp;
  logic [31:0] jmp_target;
  logic        exc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] pc_out;
`ifdef PC_SEQ_PERF_EN
  logic [31:0] perf_fetch;
  logic [31:0] perf_squash;
  logic [31:0] perf_stall;
`endif

  int checks;
  int failures;

  pc_sequencer dut (
    .clk        (clk),
    .rstn       (rstn),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .jmp        (jmp),
    .jmp_target (jmp_target),
    .exc        (exc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .if_valid   (if_valid),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
`ifdef PC_SEQ_PERF_EN
    .perf_fetch (perf_fetch),
    .perf_squash(perf_squash),
    .perf_stall (perf_stall),
`endif
    .pc_out     (pc_out)
  );

  assign imem_rdata = imem_addr ^ 32'hCAFE_0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_req"}, {31'd0, imem_req}, 32'd0);
    chk({tag, "_addr"}, imem_addr, 32'h0);
    chk({tag, "_pc"}, pc_out, 32'h0);
    chk({tag, "_v"}, {31'd0, if_valid}, 32'd0);
    chk({tag, "_ins"}, if_instr, 32'h0);
    chk({tag, "_ipc"}, if_pc, 32'h0);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rstn       = 1'b0;
    stall      = 1'b0;
    br_taken   = 1'b0;
    br_target  = '0;
    jmp        = 1'b0;
    jmp_target = '0;
    exc        = 1'b0;
    imem_ack   = 1'b1;
    #2;
    chk_rst("rst");

    // reset release, ack tied high
    @(posedge clk);
    #1 rstn = 1'b1;
    #1;
    chk("boot_req", {31'd0, imem_req}, 32'd0);
    cyc();
    chk("f0_req", {31'd0, imem_req}, 32'd1);
    chk("f0_addr", imem_addr, 32'h0);
    cyc();
    chk("f1_addr", imem_addr, 32'h4);
    chk("f1_ipc", if_pc, 32'h0);
    chk("f1_v", {31'd0, if_valid}, 32'd1);
    chk("f1_ins", if_instr, 32'hCAFE_0000);
    cyc();
    chk("f2_addr", imem_addr, 32'h8);
    chk("f2_ipc", if_pc, 32'h4);
    cyc();
    chk("f3_ipc", if_pc, 32'h8);
    chk("f3_pc", pc_out, 32'hC);

    // stall for 3 cycles with if_valid=1
    stall = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("st_req", {31'd0, imem_req}, 32'd0);
      chk("st_ipc", if_pc, 32'h8);
      chk("st_v", {31'd0, if_valid}, 32'd1);
      chk("st_ins", if_instr, 32'hCAFE_0008);
      chk("st_pc", pc_out, 32'hC);
      cyc();
    end
    stall = 1'b0;
    #1;
    chk("rel_req", {31'd0, imem_req}, 32'd1);
    chk("rel_addr", imem_addr, 32'hC);
    cyc();
    chk("rel_ipc", if_pc, 32'hC);
    chk("rel_addr2", imem_addr, 32'h10);

    // delayed ack, branch in first wait cycle
    imem_ack  = 1'b0;
    br_taken  = 1'b1;
    br_target = 32'h100;
    #1;
    chk("w1_addr", imem_addr, 32'h10);
    cyc();
    br_taken = 1'b0;
    #1;
    chk("w2_req", {31'd0, imem_req}, 32'd1);
    chk("w2_addr", imem_addr, 32'h10);
    chk("w2_v", {31'd0, if_valid}, 32'd0);
    cyc();
    chk("w3_addr", imem_addr, 32'h10);
    cyc();
    imem_ack = 1'b1;
    #1;
    chk("w4_addr", imem_addr, 32'h10);
    cyc();
    chk("br_addr", imem_addr, 32'h100);
    chk("br_v", {31'd0, if_valid}, 32'd0);

    // all three redirects together, with ack
    exc        = 1'b1;
    jmp        = 1'b1;
    jmp_target = 32'h400;
    br_taken   = 1'b1;
    br_target  = 32'h200;
    cyc();
    exc      = 1'b0;
    jmp      = 1'b0;
    br_taken = 1'b0;
    #1;
    chk("ex_addr", imem_addr, 32'h8000_0180);
    chk("ex_v", {31'd0, if_valid}, 32'd0);

    // stall with if_valid=0 still fetches
    stall = 1'b1;
    #1;
    chk("sv0_req", {31'd0, imem_req}, 32'd1);
    cyc();
    chk("sv0_ipc", if_pc, 32'h8000_0180);
    chk("sv0_ins", if_instr, 32'h4AFE_0180);
    chk("sv0_req2", {31'd0, imem_req}, 32'd0);
    stall = 1'b0;

    // misaligned jump target, then PC wrap
    jmp        = 1'b1;
    jmp_target = 32'hFFFF_FFFF;
    #1;
    cyc();
    jmp = 1'b0;
    #1;
    chk("al_pc", pc_out, 32'hFFFF_FFFC);
    cyc();
    chk("wrap_pc", pc_out, 32'h0);
    chk("wrap_ipc", if_pc, 32'hFFFF_FFFC);

    // pending exc in DRAIN is not overwritten by branch
    imem_ack = 1'b0;
    exc      = 1'b1;
    #1;
    cyc();
    exc       = 1'b0;
    br_taken  = 1'b1;
    br_target = 32'h300;
    #1;
    cyc();
    br_taken = 1'b0;
    imem_ack = 1'b1;
    #1;
    chk("dx_addr", imem_addr, 32'h0);
    cyc();
    chk("dx_pc", pc_out, 32'h8000_0180);

    // reset asserted mid-DRAIN
    imem_ack  = 1'b0;
    br_taken  = 1'b1;
    br_target = 32'h40;
    #1;
    cyc();
    br_taken = 1'b0;
    #1;
    chk("dr_req", {31'd0, imem_req}, 32'd1);
    rstn = 1'b0;
    #1;
    chk_rst("mrst");
    imem_ack = 1'b1;
    cyc();
    rstn = 1'b1;
    #1;
    chk("rb_req", {31'd0, imem_req}, 32'd0);
    cyc();
    chk("rb_req2", {31'd0, imem_req}, 32'd1);
    chk("rb_addr", imem_addr, 32'h0);
    cyc();
    chk("rb_ipc", if_pc, 32'h0);
    chk("rb_v", {31'd0, if_valid}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
